// File: rtl/divider_if.sv
// divider_if: operand/result bundle between a requester and the sequential
// divider.
//   start        request, sampled by the divider only while idle
//   Dvnd, Dvsr   two's-complement dividend / divisor, captured on acceptance
//   Y            {remainder, quotient} for the HI/LO pair
//   busy         division in progress
//   done         one-cycle completion pulse
//   div_by_zero  qualifies the most recent completion
// master = requester side, slave = divider side.
interface divider_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     Dvnd;
    logic [WIDTH-1:0]     Dvsr;
    logic [2*WIDTH-1:0]   Y;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;

    modport master (
        output start, Dvnd, Dvsr,
        input  Y, busy, done, div_by_zero
    );

    modport slave (
        input  start, Dvnd, Dvsr,
        output Y, busy, done, div_by_zero
    );
endinterface

// File: rtl/divider.sv
// divider: sequential signed restoring divider, one quotient bit per clock.
// Operands are turned into magnitudes on acceptance, divided unsigned over
// WIDTH cycles, and the signs are applied in a final FIX cycle. Latency from
// the accepting edge to done is WIDTH+1 clocks.
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    divider_if slave port (start/Dvnd/Dvsr in, Y/busy/done/div_by_zero out)
module divider #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    divider_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    // The committed remainder is always below the divisor magnitude
    // (at most 2^(WIDTH-1)), so WIDTH bits hold it; only the trial
    // subtraction needs the extra bit.
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;      // dividend magnitude shifts out, quotient shifts in
    logic [WIDTH-1:0]     r_mag_dvsr;
    logic [WIDTH-1:0]     r_dvnd;     // raw dividend, returned as HI on divide by zero
    logic                 r_sign_q;
    logic                 r_sign_r;
    logic                 r_dz;
    logic [2*WIDTH-1:0]   r_y;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dbz;

    logic [WIDTH-1:0]     w_mag_dvnd;
    logic [WIDTH-1:0]     w_mag_dvsr;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_trial;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned 2^(WIDTH-1).
    assign w_mag_dvnd = bus.Dvnd[WIDTH-1] ? -bus.Dvnd : bus.Dvnd;
    assign w_mag_dvsr = bus.Dvsr[WIDTH-1] ? -bus.Dvsr : bus.Dvsr;

    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_mag_dvsr};

    assign w_quo_fix  = r_sign_q ? -r_quo : r_quo;
    assign w_rem_fix  = r_sign_r ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_mag_dvsr <= '0;
            r_dvnd     <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_dz       <= 1'b0;
            r_y        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sign_q   <= bus.Dvnd[WIDTH-1] ^ bus.Dvsr[WIDTH-1];
                        r_sign_r   <= bus.Dvnd[WIDTH-1];
                        r_quo      <= w_mag_dvnd;
                        r_mag_dvsr <= w_mag_dvsr;
                        r_dvnd     <= bus.Dvnd;
                        r_dz       <= (bus.Dvsr == '0);
                        r_rem      <= '0;
                        r_cnt      <= CW'(WIDTH - 1);
                        r_busy     <= 1'b1;
                        r_state    <= DIV;
                    end
                end
                DIV: begin
                    // Restoring step: keep the shifted remainder when the
                    // trial goes negative, otherwise commit the difference.
                    if (w_trial[WIDTH])
                        r_rem <= w_shift[WIDTH-1:0];
                    else
                        r_rem <= w_trial[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
                    if (r_cnt == '0)
                        r_state <= FIX;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    // Divide by zero still iterates so latency is constant;
                    // the result is overridden here.
                    if (r_dz)
                        r_y <= {r_dvnd, {WIDTH{1'b1}}};
                    else
                        r_y <= {w_rem_fix, w_quo_fix};
                    r_dbz   <= r_dz;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Y           = r_y;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
endmodule
